// File: rtl/jedro_1_pkg.sv
// Shared constants for the jedro-1 decode stage: widths, ALU op codes, opcodes.
package jedro_1_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int ALU_OP_WIDTH   = 4;

  // ALU op = {variant bit, funct3}; the variant bit selects SUB/SRA.
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD  = 4'b0000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB  = 4'b1000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLL  = 4'b0001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLT  = 4'b0010;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLTU = 4'b0011;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_XOR  = 4'b0100;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRL  = 4'b0101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRA  = 4'b1101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_OR   = 4'b0110;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AND  = 4'b0111;

  localparam logic [6:0] OPCODE_OP    = 7'b0110011;
  localparam logic [6:0] OPCODE_OPIMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LUI   = 7'b0110111;

  localparam logic [6:0] FUNCT7_ZERO = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  // Sign-extend an I-type 12-bit immediate to the data width.
  function automatic logic [DATA_WIDTH-1:0] sext_imm12(input logic [11:0] imm);
    return {{(DATA_WIDTH-12){imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/jedro_1_hazard_scoreboard.sv
// Tracks the destination registers of the last DEPTH issued instructions and
// flags a read-after-write hazard for the instruction currently offered.
module jedro_1_hazard_scoreboard
  import jedro_1_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      push_valid,
  input  logic [REG_ADDR_WIDTH-1:0] push_rd,
  input  logic [REG_ADDR_WIDTH-1:0] rs1,
  input  logic [REG_ADDR_WIDTH-1:0] rs2,
  input  logic                      use_rs1,
  input  logic                      use_rs2,
  output logic                      hazard,
  output logic [DEPTH-1:0]          entry_valid
);

  logic [DEPTH-1:0]          valid_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q [DEPTH];
  logic                      hit_a;
  logic                      hit_b;

  // Shift one entry per cycle; a non-writing cycle pushes an invalid entry.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) rd_q[i] <= '0;
    end else begin
      valid_q[0] <= push_valid;
      rd_q[0]    <= push_rd;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        rd_q[i]    <= rd_q[i-1];
      end
    end
  end

  // x0 never creates a dependency, so it is excluded from the match.
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (rd_q[i] == rs1)) hit_a = 1'b1;
      if (valid_q[i] && (rd_q[i] == rs2)) hit_b = 1'b1;
    end
    hazard = (use_rs1 && (rs1 != '0) && hit_a) ||
             (use_rs2 && (rs2 != '0) && hit_b);
  end

  assign entry_valid = valid_q;

endmodule

// File: rtl/jedro_1_decoder.sv
// Decode stage: decodes OP / OP-IMM / LUI, reads the register file and
// registers the ALU operation, interlocking on its own in-flight writes.
module jedro_1_decoder
  import jedro_1_pkg::*;
#(
  parameter int HAZARD_DEPTH = 2
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [31:0]               instr_i,
  input  logic                      instr_valid_i,
  output logic                      instr_ready_o,
  output logic [REG_ADDR_WIDTH-1:0] rf_addr_a_o,
  output logic [REG_ADDR_WIDTH-1:0] rf_addr_b_o,
  input  logic [DATA_WIDTH-1:0]     rf_data_a_i,
  input  logic [DATA_WIDTH-1:0]     rf_data_b_i,
  output logic [ALU_OP_WIDTH-1:0]   alu_op_sel_o,
  output logic [DATA_WIDTH-1:0]     opa_o,
  output logic [DATA_WIDTH-1:0]     opb_o,
  output logic [REG_ADDR_WIDTH-1:0] reg_alu_dest_addr_o,
  output logic                      alu_reg_wb_o,
  output logic                      illegal_instr_o
);

  logic [6:0]                opcode;
  logic [2:0]                funct3;
  logic [6:0]                funct7;
  logic [REG_ADDR_WIDTH-1:0] rs1;
  logic [REG_ADDR_WIDTH-1:0] rs2;
  logic [REG_ADDR_WIDTH-1:0] rd;

  logic                      legal;
  logic                      use_rs1;
  logic                      use_rs2;
  logic [ALU_OP_WIDTH-1:0]   op;
  logic [DATA_WIDTH-1:0]     opa;
  logic [DATA_WIDTH-1:0]     opb;

  logic                      hazard;
  logic                      accept;
  logic                      issue;
  logic                      writes_rd;
  logic [HAZARD_DEPTH-1:0]   sb_valid_unused;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign rs1    = instr_i[19:15];
  assign rs2    = instr_i[24:20];
  assign rd     = instr_i[11:7];

  assign rf_addr_a_o = rs1;
  assign rf_addr_b_o = rs2;

  // Opcode decode, legality and operand selection for the offered instruction.
  always_comb begin
    legal   = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    op      = ALU_OP_ADD;
    opa     = '0;
    opb     = '0;
    if (instr_i[1:0] == 2'b11) begin
      case (opcode)
        OPCODE_OP: begin
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
          opa     = rf_data_a_i;
          opb     = rf_data_b_i;
          op      = {funct7[5], funct3};
          legal   = (funct7 == FUNCT7_ZERO) ||
                    ((funct7 == FUNCT7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        end
        OPCODE_OPIMM: begin
          use_rs1 = 1'b1;
          opa     = rf_data_a_i;
          if (funct3 == 3'b001) begin
            opb   = {{(DATA_WIDTH-5){1'b0}}, instr_i[24:20]};
            op    = {instr_i[30], funct3};
            legal = (funct7 == FUNCT7_ZERO);
          end else if (funct3 == 3'b101) begin
            opb   = {{(DATA_WIDTH-5){1'b0}}, instr_i[24:20]};
            op    = {instr_i[30], funct3};
            legal = (funct7 == FUNCT7_ZERO) || (funct7 == FUNCT7_ALT);
          end else begin
            opb   = sext_imm12(instr_i[31:20]);
            op    = {1'b0, funct3};
            legal = 1'b1;
          end
        end
        OPCODE_LUI: begin
          opb   = {instr_i[31:12], 12'b0};
          legal = 1'b1;
        end
        default: legal = 1'b0;
      endcase
    end
  end

  assign instr_ready_o = ~hazard;
  assign accept        = instr_valid_i & instr_ready_o;
  assign issue         = accept & legal;
  assign writes_rd     = issue & (rd != '0);

  jedro_1_hazard_scoreboard #(
    .DEPTH(HAZARD_DEPTH)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .push_valid (writes_rd),
    .push_rd    (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .use_rs1    (use_rs1),
    .use_rs2    (use_rs2),
    .hazard     (hazard),
    .entry_valid(sb_valid_unused)
  );

  // Register the issued instruction, or a bubble (ADD 0,0 to x0) when nothing issues.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      alu_op_sel_o        <= ALU_OP_ADD;
      opa_o               <= '0;
      opb_o               <= '0;
      reg_alu_dest_addr_o <= '0;
      alu_reg_wb_o        <= 1'b0;
      illegal_instr_o     <= 1'b0;
    end else begin
      illegal_instr_o <= accept & ~legal;
      if (issue) begin
        alu_op_sel_o        <= op;
        opa_o               <= opa;
        opb_o               <= opb;
        reg_alu_dest_addr_o <= rd;
        alu_reg_wb_o        <= (rd != '0);
      end else begin
        alu_op_sel_o        <= ALU_OP_ADD;
        opa_o               <= '0;
        opb_o               <= '0;
        reg_alu_dest_addr_o <= '0;
        alu_reg_wb_o        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jedro_1_decoder.sv
// Bench for the decode stage: a register file with a two-stage write-back
// path sits behind the decoder; expected issue results are queued before each
// clock edge and compared after it.
module tb_jedro_1_decoder;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [31:0] instr_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [4:0]  rf_addr_a_o;
  logic [4:0]  rf_addr_b_o;
  logic [31:0] rf_data_a_i;
  logic [31:0] rf_data_b_i;
  logic [3:0]  alu_op_sel_o;
  logic [31:0] opa_o;
  logic [31:0] opb_o;
  logic [4:0]  reg_alu_dest_addr_o;
  logic        alu_reg_wb_o;
  logic        illegal_instr_o;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [4:0]  rd;
    logic        wb;
    logic        ill;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rf [32];
  int          last_wr [32];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  logic        st1_v, st2_v;
  logic [4:0]  st1_rd, st2_rd;
  logic [31:0] st1_val, st2_val;

  jedro_1_decoder dut (
    .clk_i              (clk_i),
    .rstn_i             (rstn_i),
    .instr_i            (instr_i),
    .instr_valid_i      (instr_valid_i),
    .instr_ready_o      (instr_ready_o),
    .rf_addr_a_o        (rf_addr_a_o),
    .rf_addr_b_o        (rf_addr_b_o),
    .rf_data_a_i        (rf_data_a_i),
    .rf_data_b_i        (rf_data_b_i),
    .alu_op_sel_o       (alu_op_sel_o),
    .opa_o              (opa_o),
    .opb_o              (opb_o),
    .reg_alu_dest_addr_o(reg_alu_dest_addr_o),
    .alu_reg_wb_o       (alu_reg_wb_o),
    .illegal_instr_o    (illegal_instr_o)
  );

  always #5 clk_i = ~clk_i;

  assign rf_data_a_i = rf[rf_addr_a_o];
  assign rf_data_b_i = rf[rf_addr_b_o];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, expv, cyc);
    end
  endtask

  function automatic exp_t bubble();
    exp_t e;
    e.op = 4'b0000; e.opa = 0; e.opb = 0; e.rd = 0; e.wb = 1'b0; e.ill = 1'b0;
    return e;
  endfunction

  // Reference decode written per instruction class.
  function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    exp_t       e;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       bad;
    e   = bubble();
    f3  = ins[14:12];
    f7  = ins[31:25];
    bad = 1'b1;
    case (ins[6:0])
      7'h33: begin
        bad   = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
        e.op  = {f7 == 7'h20, f3};
        e.opa = a;
        e.opb = b;
      end
      7'h13: begin
        e.opa = a;
        if (f3 == 3'd1) begin
          bad   = (f7 != 7'h00);
          e.op  = 4'b0001;
          e.opb = {27'd0, ins[24:20]};
        end else if (f3 == 3'd5) begin
          bad   = !(f7 == 7'h00 || f7 == 7'h20);
          e.op  = (f7 == 7'h20) ? 4'b1101 : 4'b0101;
          e.opb = {27'd0, ins[24:20]};
        end else begin
          bad   = 1'b0;
          e.op  = {1'b0, f3};
          e.opb = {{20{ins[31]}}, ins[31:20]};
        end
      end
      7'h37: begin
        bad   = 1'b0;
        e.opb = {ins[31:12], 12'h000};
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      e = bubble();
      e.ill = 1'b1;
    end else begin
      e.rd = ins[11:7];
      e.wb = (ins[11:7] != 5'd0);
    end
    return e;
  endfunction

  function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a << b[4:0];
      4'b0010: return {31'd0, $signed(a) < $signed(b)};
      4'b0011: return {31'd0, a < b};
      4'b0100: return a ^ b;
      4'b0101: return a >> b[4:0];
      4'b1101: return $unsigned($signed(a) >>> b[4:0]);
      4'b0110: return a | b;
      4'b0111: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic busy(input logic [4:0] r);
    return (r != 5'd0) && ((cyc - last_wr[r]) <= 2);
  endfunction

  // One clock: drive, predict ready and the registered result, clock, compare.
  task automatic step(input logic [31:0] ins, input logic vld, input logic rn, output logic acc);
    exp_t       e;
    logic       rdy, u1, u2;
    logic [4:0] r1, r2;
    instr_i       = ins;
    instr_valid_i = vld;
    rstn_i        = rn;
    #1;
    r1  = ins[19:15];
    r2  = ins[24:20];
    u1  = (ins[6:0] == 7'h33) || (ins[6:0] == 7'h13);
    u2  = (ins[6:0] == 7'h33);
    rdy = !((u1 && busy(r1)) || (u2 && busy(r2)));
    if (cyc > 0) check("ready", {31'd0, instr_ready_o}, {31'd0, rdy});
    check("addr_a", {27'd0, rf_addr_a_o}, {27'd0, r1});
    check("addr_b", {27'd0, rf_addr_b_o}, {27'd0, r2});
    acc = rn && vld && rdy;
    e   = acc ? ref_dec(ins, rf[r1], rf[r2]) : bubble();
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
    cyc++;
    check("queue_depth", exp_q.size(), 1);
    e = exp_q.pop_front();
    check("op",  {28'd0, alu_op_sel_o}, {28'd0, e.op});
    check("opa", opa_o, e.opa);
    check("opb", opb_o, e.opb);
    check("rd",  {27'd0, reg_alu_dest_addr_o}, {27'd0, e.rd});
    check("wb",  {31'd0, alu_reg_wb_o}, {31'd0, e.wb});
    check("illegal", {31'd0, illegal_instr_o}, {31'd0, e.ill});
    if (!rn) begin
      for (int i = 0; i < 32; i++) last_wr[i] = -100;
    end else if (e.wb) begin
      last_wr[e.rd] = cyc - 1;
    end
    if (st2_v) rf[st2_rd] = st2_val;
    st2_v = st1_v; st2_rd = st1_rd; st2_val = st1_val;
    st1_v = e.wb;  st1_rd = e.rd;   st1_val = alu(e.op, e.opa, e.opb);
  endtask

  // Present an instruction until it is accepted; compare the stall count.
  task automatic issue(input string tag, input logic [31:0] ins, input int exp_stalls);
    logic acc;
    int   stalls;
    stalls = 0;
    acc    = 1'b0;
    for (int i = 0; i < 8 && !acc; i++) begin
      step(ins, 1'b1, 1'b1, acc);
      if (!acc) stalls++;
    end
    check({tag, "_stalls"}, stalls, exp_stalls);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, r1, r2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    int          sel;
    rd  = 5'($urandom_range(0, 7));
    r1  = 5'($urandom_range(0, 7));
    r2  = 5'($urandom_range(0, 7));
    f3  = 3'($urandom);
    sel = $urandom_range(0, 2);
    f7  = (sel == 0) ? 7'h00 : (sel == 1) ? 7'h20 : 7'($urandom);
    sel = $urandom_range(0, 9);
    if (sel < 4)      return {f7, r2, r1, f3, rd, 7'h33};
    else if (sel < 7) return {f7, r2, r1, f3, rd, 7'h13};
    else if (sel < 9) return {20'($urandom), rd, 7'h37};
    else              return $urandom;
  endfunction

  initial begin
    logic acc;
    for (int i = 0; i < 32; i++) begin
      rf[i]      = 32'd0;
      last_wr[i] = -100;
    end
    st1_v = 0; st2_v = 0; st1_rd = 0; st2_rd = 0; st1_val = 0; st2_val = 0;

    // Reset with a valid instruction held; nothing issues, ready stays high.
    step(32'h00500093, 1'b1, 1'b0, acc);
    step(32'h00500093, 1'b1, 1'b0, acc);
    check("ready_in_reset", {31'd0, instr_ready_o}, 32'd1);

    // ADDI x1,x0,5 then dependent ADD x2,x1,x1.
    issue("addi_x1", 32'h00500093, 0);
    check("addi_opb", opb_o, 32'd5);
    issue("add_x2", 32'h00108133, 2);
    check("add_opa", opa_o, 32'd5);
    check("add_opb", opb_o, 32'd5);

    // LUI x1,0x80000; SRAI x4,x1,3; SUB x3,x2,x1.
    issue("lui_x1", 32'h800000B7, 0);
    issue("srai", 32'h4030D213, 2);
    check("srai_op", {28'd0, alu_op_sel_o}, 32'hD);
    check("srai_opa", opa_o, 32'h80000000);
    issue("sub", 32'h401101B3, 0);
    check("sub_op", {28'd0, alu_op_sel_o}, 32'h8);

    // LUI right behind a write to x1 does not stall.
    issue("addi_x1b", 32'h00700093, 0);
    issue("lui_x5", 32'h123452B7, 0);
    check("lui_opb", opb_o, 32'h12345000);

    // Illegal instructions: accepted, pulse, no scoreboard entry.
    step(32'h0, 1'b0, 1'b1, acc);
    step(32'h0, 1'b0, 1'b1, acc);
    issue("ill_zero", 32'h00000000, 0);
    check("ill_pulse0", {31'd0, illegal_instr_o}, 32'd1);
    issue("ill_f7", 32'h4020F1B3, 0);
    check("ill_pulse1", {31'd0, illegal_instr_o}, 32'd1);
    issue("add_x9_x3", 32'h003184B3, 0);
    check("ill_dropped", {31'd0, illegal_instr_o}, 32'd0);

    // x0 destination: no write-back, no interlock.
    issue("addi_x0", 32'h00100013, 0);
    check("x0_wb", {31'd0, alu_reg_wb_o}, 32'd0);
    issue("add_x6", 32'h00000333, 0);

    // Reset in the middle of a stall clears the interlock.
    issue("addi_x7", 32'h00300393, 0);
    step(32'h00738433, 1'b1, 1'b1, acc);
    step(32'h00738433, 1'b1, 1'b0, acc);
    issue("add_x8", 32'h00738433, 0);

    // Random mix of legal, illegal, dependent and idle cycles.
    for (int i = 0; i < 200; i++) begin
      step(rand_instr(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) != 0), acc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jedro_1_decoder.md
Name: jedro_1_decoder

Overview:
- Decode stage of riscv-jedro-1; the producer end of the ALU operand/opcode interface.
- Accepts RV32I OP, OP-IMM and LUI instructions from fetch over a valid/ready handshake.
- Reads the register file combinationally and registers ALU opcode, operands, destination address and write-back enable.
- Interlocks on read-after-write hazards against its own in-flight instructions with a 2-deep scoreboard.

Parameters:
- HAZARD_DEPTH, 2, number of issued instructions whose rd is still unwritten in the register file (ALU register stage plus RF write).

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset; synchronous, active-low.
- instr_i  in  32  instruction word from fetch.
- instr_valid_i  in  1  instr_i is valid.
- instr_ready_o  out  1  decoder accepts instr_i this cycle; combinational.
- rf_addr_a_o  out  5  register-file read address A = instr_i[19:15]; combinational.
- rf_addr_b_o  out  5  register-file read address B = instr_i[24:20]; combinational.
- rf_data_a_i  in  32  read data A, same cycle.
- rf_data_b_i  in  32  read data B, same cycle.
- alu_op_sel_o  out  ALU_OP_WIDTH(4)  ALU operation; registered.
- opa_o  out  32  operand A; registered.
- opb_o  out  32  operand B; registered.
- reg_alu_dest_addr_o  out  5  rd; registered.
- alu_reg_wb_o  out  1  result must be written back; registered.
- illegal_instr_o  out  1  one-cycle pulse, accepted instruction was illegal; registered.

Behaviour:
- Reset (rstn_i=0 at posedge): all registered outputs 0, scoreboard cleared. Reset mid-stall drops the pending instruction; fetch must re-present it.
- Accept: instruction consumed at a posedge where instr_valid_i & instr_ready_o.
- Ready: instr_ready_o = ~hazard. hazard = a used, non-zero rs1/rs2 of instr_i matches a valid scoreboard entry.
  - OP uses rs1 and rs2.
  - OP-IMM uses rs1.
  - LUI uses neither.
- Latency: outputs valid in the cycle after acceptance.
- Bubble: any cycle with no accept (invalid, stalled or illegal) registers op=ADD, opa=opb=0, rd=0, wb=0.
- Scoreboard: shift register of HAZARD_DEPTH {valid, rd} entries, shifted every cycle. The new entry is {accepted & wb, rd}. A RAW-dependent instruction therefore stalls exactly 2 cycles behind its producer.
- ALU op encoding is {bit3, funct3}: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111. Bit3 selects SUB/SRA.
- OP (0110011):
  - opa = rf_data_a_i, opb = rf_data_b_i.
  - bit3 = funct7[5].
  - funct7 must be 0000000, or 0100000 with funct3 000 or 101; anything else is illegal.
- OP-IMM (0010011):
  - opa = rf_data_a_i.
  - funct3 001/101: opb = zero-extended shamt instr[24:20]. bit3 = instr[30]. SLLI requires funct7 = 0000000; SRLI/SRAI require funct7 = 0000000 or 0100000; anything else is illegal.
  - Other funct3: opb = sign-extended instr[31:20], bit3 = 0.
- LUI (0110111): opa = 0, opb = {instr[31:12], 12'b0}, op = ADD.
- Any other opcode, or instr[1:0] != 11, is illegal.
- Illegal instruction: accepted, issued as a bubble, illegal_instr_o = 1 for one cycle, no scoreboard entry.
- rd = x0: alu_reg_wb_o = 0, no scoreboard entry; the instruction still issues.
- Back-to-back independent instructions issue every cycle.

Decomposition:
- jedro_1_defines.v holds ALU_OP_WIDTH, all ALU_OP_* codes above, OPCODE_OP / OPCODE_OPIMM / OPCODE_LUI, DATA_WIDTH, REG_ADDR_WIDTH.
- Natural sub-module: jedro_1_hazard_scoreboard, holding the scoreboard shift register and match logic, with outputs hazard and the entry valid bits.
- Immediate generation and opcode decode stay inline.

Test Plan:
- Reset with instr_valid_i=1 and instr 0x00500093 → all outputs 0 and instr_ready_o=1 throughout reset. First post-reset cycle: op=0000, opa=0, opb=5, rd=1, wb=1.
- ADDI x1,x0,5 (0x00500093) then ADD x2,x1,x1 (0x00108133), RF model with 2-cycle write-back → ready low exactly 2 cycles, then ADD issues with opa=opb=5, rd=2, op=0000.
- SRAI x4,x1,3 (0x4030D213) with x1=0x80000000 → op=1101, opb=3, rd=4. SUB x3,x2,x1 (0x401101B3) → op=1000.
- LUI x5,0x12345 (0x123452B7) directly after a write to x1 → no stall; opa=0, opb=0x12345000, rd=5, wb=1.
- 0x00000000 and OP with funct7=0100000, funct3=111 (0x4020F1B3) → accepted, illegal_instr_o pulses 1 cycle each, bubble issued, no scoreboard entry.
- ADDI x0,x0,1 (0x00100013) followed by ADD x6,x0,x0 → first issues with wb=0; second issues next cycle with no stall.
